imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream loader that fills the processor's writable instruction memory before execution. It accepts a length-prefixed, XOR-checksummed byte stream over a valid/ready handshake and assembles bytes into N-bit words. It issues one write per word to the instruction memory write port, at addresses 0 upward. It holds the single-cycle core in reset (`cpu_hold`) while a load is in progress or has failed.

## Interface
- `N`, 32, instruction word width; multiple of 8; bytes per word `B = N/8`.
- `AW`, 6, instruction memory address width (64 words).

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; honoured only in IDLE, DONE or ERR.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  instruction memory write strobe, one cycle per word.
- `waddr`  out  AW  write word address.
- `wdata`  out  N  write data.
- `busy`  out  1  state is LEN, DATA or CHK.
- `done`  out  1  sticky; last load succeeded.
- `err`  out  1  sticky; last load failed.
- `cpu_hold`  out  1  keep core in reset.

## Operation
- Stream format: length byte `L` (number of words minus 1), then `(L+1)*B` data bytes, then one checksum byte equal to the XOR of all data bytes. The length byte is not included in the checksum.
- Byte order within a word: first byte received goes to bits N-1:N-8 (big-endian).
- A byte is accepted on a cycle where `rx_valid && rx_ready`. `rx_ready` = 1 exactly in LEN, DATA and CHK; it is combinational from state only.
- State machine:
  - IDLE: wait for `start`.
  - In IDLE, DONE or ERR, `start` moves to LEN and clears `done`, `err`, the checksum accumulator, the byte counter and the word counter.
  - LEN, on an accepted byte: if bits 7:AW are nonzero, go to ERR. Otherwise store `L` = byte[AW-1:0] and go to DATA.
  - DATA, on each accepted byte: shift the byte into the word register and XOR it into the checksum.
    - On the B-th byte of a word, schedule a write of that word at the current word address, then increment the word address.
    - After word `L` is complete, go to CHK.
  - CHK, on an accepted byte: if it equals the checksum, go to DONE (`done`=1); otherwise go to ERR (`err`=1).
  - DONE and ERR hold until `start` or `reset`.
- `start` is ignored while `busy`.
- `cpu_hold` = 1 in LEN, DATA, CHK and ERR; 0 in IDLE and DONE.
- Word address never wraps: at most `2^AW` words, addresses 0..L.
- Previously written memory is not erased on error or reset. Partial words are discarded.

## Timing
- Reset values: state IDLE; `rx_ready`, `we`, `busy`, `done`, `err`, `cpu_hold` = 0; `waddr` = 0; `wdata` = 0.
- `start` accepted at edge t: LEN from t+1; `rx_ready`=1 and `cpu_hold`=1 in that cycle.
- Write latency: the B-th byte of a word is accepted at edge t. `we`=1 with valid `waddr`/`wdata` during cycle t+1 only. `waddr`/`wdata` hold their last value while `we`=0.
- No back-pressure: `rx_ready` stays 1 through DATA. Bytes may arrive on consecutive cycles, and the write for one word overlaps reception of the next.
- `rx_valid` gaps of any length are allowed. State and counters hold while no byte is accepted.
- The final word's `we` cycle coincides with the first CHK cycle.
- CHK byte accepted at edge t: `done`/`err` = 1 and `busy` = 0 from t+1.
- `start` and `rx_valid` in the same IDLE cycle: `rx_ready` is 0, so the byte is not consumed.
- `reset` mid-load: back to IDLE at the next edge with reset values. A pending `we` is cancelled.

## Test plan
- Single word: reset; `start`; bytes 00, F8, 00, 00, 01, F9 on consecutive cycles. Expect `we` for exactly one cycle with `waddr`=0 and `wdata`=f8000001, one cycle after byte 01. Then `done`=1, `cpu_hold`=0, `err`=0.
- Two words with gaps: bytes 01, F8 00 80 02, F8 00 02 03, 83, with random `rx_valid` idle cycles between bytes. Expect writes (0, f8008002) and (1, f8000203), then `done`=1.
- Bad checksum: same as the first scenario but checksum byte F8. Expect the word written at address 0, then `err`=1, `done`=0, `cpu_hold` still 1. A following `start` clears `err`.
- Illegal length: `start`, length byte 40. Expect `err`=1 on the next cycle, no `we`, and `rx_ready`=0 afterwards.
- Full depth: `L`=3F, 64 words with `wdata` = {8'hA0+i[5:0]...} pattern, correct checksum. Expect 64 writes at addresses 0..63 in order, no write to address 0 after 63, then `done`=1.
- Reset mid-word: after the length byte and 2 data bytes, pulse `reset`. Expect all outputs at reset values. A new clean single-word load then writes exactly the new word at address 0, with no leftover bytes.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed, XOR-checked byte loader
// that fills instruction memory and holds the core.
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [N-1:0]  wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold
);

  localparam int B  = N / 8;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [BW-1:0] BLAST = BW'(B - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0] len;
  logic [AW-1:0] wcnt;
  logic [BW-1:0] bcnt;
  logic [N-1:0]  word;
  logic [N-1:0]  word_nx;
  logic [7:0]    csum;
  logic          we_r;
  logic [AW-1:0] waddr_r;
  logic [N-1:0]  wdata_r;

  logic acc;
  logic idle_like;
  logic go;
  logic last_byte;
  logic last_word;
  logic len_bad;

  // handshake and per-byte decode
  always_comb begin
    rx_ready  = (state == S_LEN) ||
                (state == S_DATA) ||
                (state == S_CHK);
    acc       = rx_valid && rx_ready;
    idle_like = (state == S_IDLE) ||
                (state == S_DONE) ||
                (state == S_ERR);
    go        = start && idle_like;
    last_byte = (bcnt == BLAST);
    last_word = (wcnt == len);
    len_bad   = ((rx_data >> AW) != 8'd0);
    word_nx   = (word << 8) | N'(rx_data);
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nx = S_LEN;
      end
      S_LEN: begin
        if (acc) state_nx = len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (acc && last_byte && last_word)
          state_nx = S_CHK;
      end
      S_CHK: begin
        if (acc)
          state_nx = (rx_data == csum) ? S_DONE : S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // counters, word assembly, checksum and write port
  always_ff @(posedge clk) begin
    if (reset) begin
      len     <= '0;
      wcnt    <= '0;
      bcnt    <= '0;
      word    <= '0;
      csum    <= '0;
      we_r    <= 1'b0;
      waddr_r <= '0;
      wdata_r <= '0;
    end else begin
      we_r <= 1'b0;
      if (go) begin
        csum <= '0;
        bcnt <= '0;
        wcnt <= '0;
        word <= '0;
      end
      if (acc && state == S_LEN && !len_bad)
        len <= rx_data[AW-1:0];
      if (acc && state == S_DATA) begin
        word <= word_nx;
        csum <= csum ^ rx_data;
        if (last_byte) begin
          bcnt    <= '0;
          we_r    <= 1'b1;
          waddr_r <= wcnt;
          wdata_r <= word_nx;
          if (!last_word) wcnt <= wcnt + 1'b1;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  // status outputs decoded from state
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b0;
    unique case (1'b1)
      (state == S_LEN),
      (state == S_DATA),
      (state == S_CHK): begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      (state == S_ERR): begin
        err      = 1'b1;
        cpu_hold = 1'b1;
      end
      (state == S_DONE): done = 1'b1;
      default: ;
    endcase
  end

  assign we    = we_r;
  assign waddr = waddr_r;
  assign wdata = wdata_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the loader
// stream format, write timing, errors and reset.
module tb_imem_loader;

  localparam int N  = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_hold;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] aq[$];
  logic [N-1:0]  dq[$];

  imem_loader #(.N(N), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  // record every write strobe
  always @(negedge clk) begin
    if (we) begin
      aq.push_back(waddr);
      dq.push_back(wdata);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b,
                      input int gap);
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    chk("rdy", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    aq.delete();
    dq.delete();
  endtask

  logic [7:0] cs;
  logic [7:0] bb[4];
  logic [N-1:0] w;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", rx_ready, 0);
    chk("rst_we",    we,       0);
    chk("rst_busy",  busy,     0);
    chk("rst_done",  done,     0);
    chk("rst_err",   err,      0);
    chk("rst_hold",  cpu_hold, 0);
    chk("rst_waddr", waddr,    0);
    chk("rst_wdata", wdata,    0);

    // single word
    clear_log();
    pulse_start();
    chk("t1_len_ready", rx_ready, 1);
    chk("t1_len_hold",  cpu_hold, 1);
    chk("t1_len_busy",  busy,     1);
    send(8'h00, 0);
    send(8'hF8, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("t1_pre_we", we, 0);
    send(8'h01, 0);
    chk("t1_we",    we,    1);
    chk("t1_waddr", waddr, 0);
    chk("t1_wdata", wdata, 32'hf8000001);
    chk("t1_chk_busy", busy, 1);
    send(8'hF9, 0);
    chk("t1_we_off", we,       0);
    chk("t1_done",   done,     1);
    chk("t1_err",    err,      0);
    chk("t1_hold",   cpu_hold, 0);
    chk("t1_busy",   busy,     0);
    chk("t1_nwr",    aq.size(), 1);
    chk("t1_wdata_hold", wdata, 32'hf8000001);

    // two words with gaps
    clear_log();
    pulse_start();
    chk("t2_done_clr", done, 0);
    send(8'h01, $urandom_range(0, 3));
    send(8'hF8, $urandom_range(0, 3));
    send(8'h00, $urandom_range(0, 3));
    send(8'h80, $urandom_range(0, 3));
    send(8'h02, $urandom_range(0, 3));
    send(8'hF8, $urandom_range(0, 3));
    send(8'h00, $urandom_range(0, 3));
    send(8'h02, $urandom_range(0, 3));
    send(8'h03, $urandom_range(0, 3));
    send(8'h83, $urandom_range(0, 3));
    chk("t2_done", done, 1);
    chk("t2_nwr",  aq.size(), 2);
    if (aq.size() == 2) begin
      chk("t2_a0", aq[0], 0);
      chk("t2_d0", dq[0], 32'hf8008002);
      chk("t2_a1", aq[1], 1);
      chk("t2_d1", dq[1], 32'hf8000203);
    end

    // bad checksum
    clear_log();
    pulse_start();
    send(8'h00, 0);
    send(8'hF8, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'hF8, 0);
    chk("t3_err",  err,      1);
    chk("t3_done", done,     0);
    chk("t3_hold", cpu_hold, 1);
    chk("t3_nwr",  aq.size(), 1);
    if (aq.size() == 1) begin
      chk("t3_a0", aq[0], 0);
      chk("t3_d0", dq[0], 32'hf8000001);
    end
    repeat (3) tick();
    chk("t3_err_sticky", err, 1);
    pulse_start();
    chk("t3_err_clr", err, 0);

    // illegal length
    clear_log();
    send(8'h40, 0);
    chk("t4_err",   err,      1);
    chk("t4_we",    we,       0);
    chk("t4_ready", rx_ready, 0);
    chk("t4_busy",  busy,     0);
    tick();
    chk("t4_ready2", rx_ready, 0);
    chk("t4_nwr",    aq.size(), 0);

    // full depth, 64 words
    clear_log();
    pulse_start();
    send(8'h3F, 0);
    cs = 8'h00;
    for (int i = 0; i < 64; i++) begin
      bb[0] = 8'hA0 + 8'(i);
      bb[1] = 8'(i);
      bb[2] = 8'h5A;
      bb[3] = 8'(i) ^ 8'h0F;
      for (int k = 0; k < 4; k++) begin
        cs ^= bb[k];
        send(bb[k], (i % 5 == 0) ? 1 : 0);
      end
    end
    chk("t5_busy", busy, 1);
    send(cs, 0);
    chk("t5_done", done, 1);
    chk("t5_nwr",  aq.size(), 64);
    if (aq.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        w = {8'hA0 + 8'(i), 8'(i), 8'h5A,
             8'(i) ^ 8'h0F};
        if (aq[i] != AW'(i) || dq[i] != w) begin
          chk("t5_a", aq[i], i);
          chk("t5_d", dq[i], w);
        end
      end
      chk("t5_last_a", aq[63], 63);
    end

    // reset mid-word
    clear_log();
    pulse_start();
    send(8'h00, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_ready", rx_ready, 0);
    chk("t6_we",    we,       0);
    chk("t6_busy",  busy,     0);
    chk("t6_done",  done,     0);
    chk("t6_err",   err,      0);
    chk("t6_hold",  cpu_hold, 0);
    chk("t6_waddr", waddr,    0);
    chk("t6_wdata", wdata,    0);
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    chk("t6_nocons_busy", busy, 1);
    chk("t6_nocons_err",  err,  0);
    send(8'h00, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'h56, 0);
    send(8'h78, 0);
    send(8'h08, 0);
    chk("t6_done2", done, 1);
    chk("t6_nwr",   aq.size(), 1);
    if (aq.size() == 1) begin
      chk("t6_a0", aq[0], 0);
      chk("t6_d0", dq[0], 32'h12345678);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
